// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared depth helper and status-bit indices for fifo_flagged
package fifo_pkg;

    function automatic int depth_f(input int aw);
        return 1 << aw;
    endfunction

    // Bit positions of the status word, in the order scoreboards report them.
    typedef enum logic [2:0] {
        ST_FULL   = 3'd0,
        ST_AFULL  = 3'd1,
        ST_EMPTY  = 3'd2,
        ST_AEMPTY = 3'd3,
        ST_OVF    = 3'd4,
        ST_UNF    = 3'd5
    } status_idx_e;

    localparam int STATUS_W = 6;

endpackage

// File: rtl/fifo_flagged_if.sv
// rtl/fifo_flagged_if.sv - write/read handshake and status bundle for fifo_flagged
interface fifo_flagged_if #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 8
);
    logic                  clr;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  full;
    logic                  almost_full;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  empty;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output clr, wr_en, wdata, rd_en,
        input  full, almost_full, rdata, empty, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  clr, wr_en, wdata, rd_en,
        output full, almost_full, rdata, empty, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/fifo_ram.sv
// rtl/fifo_ram.sv - DEPTH x DATA_WIDTH register file, sync write, async read
module fifo_ram #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // Storage is deliberately unreset; occupancy tracking makes stale words unreachable.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/fifo_flagged.sv
// rtl/fifo_flagged.sv - synchronous FIFO with count, thresholds, sticky errors, flush; FIFO_FWFT_EN selects fall-through read
module fifo_flagged
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH    = 3,
    parameter int DATA_WIDTH    = 8,
    parameter int AFULL_THRESH  = 6,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic           clk,
    input  logic           reset,
    fifo_flagged_if.slave  bus
);
    localparam int DEPTH = depth_f(ADDR_WIDTH);
    localparam int CW    = ADDR_WIDTH + 1;

    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THRESH);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THRESH);

    if (ADDR_WIDTH < 1) begin : g_bad_aw
        $error("fifo_flagged: ADDR_WIDTH must be at least 1");
    end
    if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull
        $error("fifo_flagged: AFULL_THRESH must lie in 1..DEPTH");
    end
    if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH - 1) begin : g_bad_aempty
        $error("fifo_flagged: AEMPTY_THRESH must lie in 0..DEPTH-1");
    end

    logic [CW-1:0]         wr_ptr;
    logic [CW-1:0]         rd_ptr;
    logic [CW-1:0]         count_q;
    logic                  ovf_q;
    logic                  unf_q;
    logic                  full;
    logic                  empty;
    logic                  wr_acc;
    logic                  rd_acc;
    logic [DATA_WIDTH-1:0] ram_rdata;

    assign full   = (count_q == DEPTH_C);
    assign empty  = (count_q == '0);
    assign wr_acc = bus.wr_en & ~full;
    assign rd_acc = bus.rd_en & ~empty;

    fifo_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc & ~bus.clr),
        .waddr (wr_ptr[ADDR_WIDTH-1:0]),
        .wdata (bus.wdata),
        .raddr (rd_ptr[ADDR_WIDTH-1:0]),
        .rdata (ram_rdata)
    );

    // Flush wins over any same-cycle traffic; memory contents are left in place.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else if (bus.clr) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + CW'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + CW'(1);
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            if (bus.wr_en && full) begin
                ovf_q <= 1'b1;
            end
            if (bus.rd_en && empty) begin
                unf_q <= 1'b1;
            end
        end
    end

`ifdef FIFO_FWFT_EN
    // Head word is presented as soon as it is stored; rd_en only advances the pointer.
    assign bus.rdata = empty ? '0 : ram_rdata;
`else
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (rd_acc && !bus.clr) begin
            rdata_q <= ram_rdata;
        end
    end

    assign bus.rdata = rdata_q;
`endif

    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (count_q >= AFULL_C);
    assign bus.almost_empty = (count_q <= AEMPTY_C);
    assign bus.count        = count_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;
endmodule

// File: tb/tb_fifo_flagged.sv
// tb/tb_fifo_flagged.sv - randomized and directed self-checking bench for fifo_flagged
module tb_fifo_flagged;
    import fifo_pkg::*;

    localparam int AW    = 3;
    localparam int DW    = 8;
    localparam int AF    = 6;
    localparam int AE    = 2;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    bit   chk_en = 1'b0;

    always #5 clk = ~clk;

    fifo_flagged_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    fifo_flagged #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .AFULL_THRESH  (AF),
        .AEMPTY_THRESH (AE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Reference: a queue of stored words plus two sticky bits and the last popped word.
    logic [DW-1:0] q[$];
    bit            m_ovf;
    bit            m_unf;
    logic [DW-1:0] m_rdata;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete();
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
            m_rdata = '0;
        end else if (bus.clr) begin
            q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            bit was_full;
            bit was_empty;
            was_full  = (q.size() == DEPTH);
            was_empty = (q.size() == 0);
            if (bus.wr_en && was_full)  m_ovf = 1'b1;
            if (bus.rd_en && was_empty) m_unf = 1'b1;
            if (bus.rd_en && !was_empty) m_rdata = q.pop_front();
            if (bus.wr_en && !was_full)  q.push_back(bus.wdata);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] exp_rdata();
`ifdef FIFO_FWFT_EN
        return (q.size() != 0) ? q[0] : '0;
`else
        return m_rdata;
`endif
    endfunction

    string st_name[STATUS_W] = '{"full", "almost_full", "empty", "almost_empty", "overflow", "underflow"};

    always @(negedge clk) begin
        if (chk_en) begin
            logic [STATUS_W-1:0] act_st;
            logic [STATUS_W-1:0] exp_st;
            act_st[ST_FULL]   = bus.full;
            act_st[ST_AFULL]  = bus.almost_full;
            act_st[ST_EMPTY]  = bus.empty;
            act_st[ST_AEMPTY] = bus.almost_empty;
            act_st[ST_OVF]    = bus.overflow;
            act_st[ST_UNF]    = bus.underflow;
            exp_st[ST_FULL]   = (q.size() == DEPTH);
            exp_st[ST_AFULL]  = (q.size() >= AF);
            exp_st[ST_EMPTY]  = (q.size() == 0);
            exp_st[ST_AEMPTY] = (q.size() <= AE);
            exp_st[ST_OVF]    = m_ovf;
            exp_st[ST_UNF]    = m_unf;
            for (int i = 0; i < STATUS_W; i++) begin
                chk({"model ", st_name[i]}, 32'(act_st[i]), 32'(exp_st[i]));
            end
            chk("model count", 32'(bus.count), 32'(q.size()));
            chk("model rdata", 32'(bus.rdata), 32'(exp_rdata()));
        end
    end

    task automatic step(input bit c, input bit w, input logic [DW-1:0] d, input bit r);
        bus.clr   = c;
        bus.wr_en = w;
        bus.wdata = d;
        bus.rd_en = r;
        @(negedge clk);
        bus.clr   = 1'b0;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        bus.clr   = 1'b0;
        bus.wr_en = 1'b0;
        bus.wdata = '0;
        bus.rd_en = 1'b0;
        repeat (2) @(negedge clk);
        reset  = 1'b0;
        chk_en = 1'b1;

        chk("reset count", 32'(bus.count), 0);
        chk("reset empty", 32'(bus.empty), 1);
        chk("reset almost_empty", 32'(bus.almost_empty), 1);
        chk("reset full", 32'(bus.full), 0);
        chk("reset almost_full", 32'(bus.almost_full), 0);
        chk("reset rdata", 32'(bus.rdata), 0);
        chk("reset overflow", 32'(bus.overflow), 0);
        chk("reset underflow", 32'(bus.underflow), 0);

        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 1'b1, DW'(i), 1'b0);
            chk("fill count", 32'(bus.count), 32'(i));
            chk("fill almost_empty", 32'(bus.almost_empty), 32'(i <= 2));
            chk("fill almost_full", 32'(bus.almost_full), 32'(i >= 6));
            chk("fill full", 32'(bus.full), 32'(i == 8));
        end
        step(1'b0, 1'b1, 8'hFF, 1'b0);
        chk("ninth write overflow", 32'(bus.overflow), 1);
        chk("ninth write count", 32'(bus.count), 8);

        for (int i = 1; i <= 8; i++) begin
`ifdef FIFO_FWFT_EN
            chk("drain rdata", 32'(bus.rdata), 32'(i));
            step(1'b0, 1'b0, '0, 1'b1);
`else
            step(1'b0, 1'b0, '0, 1'b1);
            chk("drain rdata", 32'(bus.rdata), 32'(i));
`endif
        end
        chk("drained empty", 32'(bus.empty), 1);
        step(1'b0, 1'b0, '0, 1'b1);
        chk("extra read underflow", 32'(bus.underflow), 1);
`ifdef FIFO_FWFT_EN
        chk("extra read rdata", 32'(bus.rdata), 0);
`else
        chk("extra read rdata", 32'(bus.rdata), 8);
`endif

        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, DW'(8'h10 + i), 1'b0);
        for (int j = 0; j < 20; j++) begin
`ifdef FIFO_FWFT_EN
            chk("stream rdata", 32'(bus.rdata), 32'(8'h10 + j));
            step(1'b0, 1'b1, DW'(8'h14 + j), 1'b1);
`else
            step(1'b0, 1'b1, DW'(8'h14 + j), 1'b1);
            chk("stream rdata", 32'(bus.rdata), 32'(8'h10 + j));
`endif
            chk("stream count", 32'(bus.count), 4);
        end

        step(1'b1, 1'b0, '0, 1'b0);
        chk("clr count", 32'(bus.count), 0);
        chk("clr overflow", 32'(bus.overflow), 0);
        chk("clr underflow", 32'(bus.underflow), 0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, DW'(8'h30 + i), 1'b0);
        step(1'b0, 1'b1, 8'hEE, 1'b1);
        chk("full both count", 32'(bus.count), 7);
        chk("full both overflow", 32'(bus.overflow), 1);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b1, 8'h55, 1'b1);
        chk("empty both count", 32'(bus.count), 1);
        chk("empty both underflow", 32'(bus.underflow), 1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, DW'(8'h56 + i), 1'b0);
        chk("pre-clr count", 32'(bus.count), 5);
        step(1'b1, 1'b1, 8'hAA, 1'b0);
        chk("clr+wr count", 32'(bus.count), 0);
        chk("clr+wr empty", 32'(bus.empty), 1);
        chk("clr+wr overflow", 32'(bus.overflow), 0);
        chk("clr+wr underflow", 32'(bus.underflow), 0);
        step(1'b0, 1'b1, 8'h77, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1);
        chk("post-clr rdata", 32'(bus.rdata), (32'h77 & {32{1'b1}}) & 32'(`ifdef FIFO_FWFT_EN 0 `else 8'hFF `endif));

        for (int k = 0; k < 400; k++) begin
            step($urandom_range(0, 31) == 0, $urandom_range(0, 1) == 1,
                 DW'($urandom), $urandom_range(0, 2) != 0);
        end

        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, DW'(8'hC0 + i), 1'b0);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async reset count", 32'(bus.count), 0);
        chk("async reset empty", 32'(bus.empty), 1);
        chk("async reset full", 32'(bus.full), 0);
        chk("async reset rdata", 32'(bus.rdata), 0);
        chk("async reset overflow", 32'(bus.overflow), 0);
        @(negedge clk);
        reset = 1'b0;
        step(1'b0, 1'b1, 8'h9A, 1'b0);
        chk("after reset count", 32'(bus.count), 1);
        step(1'b0, 1'b0, '0, 1'b1);
        chk("after reset empty", 32'(bus.empty), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
